// File: rtl/timestamp_insertion_multi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | timestamp_insertion_multi_pkg: mode and state encodings for the stamper  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package timestamp_insertion_multi_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_TUSER  = 2'd1;
  localparam logic [1:0] MODE_TDATA  = 2'd2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fallthrough_small_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fallthrough_small_fifo: FIFO whose head is visible on dout when !empty   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fallthrough_small_fifo #(
  parameter int WIDTH          = 8,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             empty
);

  localparam int c_DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          r_mem [c_DEPTH];
  logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
  logic [MAX_DEPTH_BITS:0]   r_count;
  logic                      w_do_wr;
  logic                      w_do_rd;

  assign w_do_wr     = wr_en && !full;
  assign w_do_rd     = rd_en && !empty;
  assign dout        = r_mem[r_rd_ptr];
  assign empty       = (r_count == '0);
  assign full        = (r_count == (MAX_DEPTH_BITS+1)'(c_DEPTH));
  assign nearly_full = (r_count >= (MAX_DEPTH_BITS+1)'(c_DEPTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/timestamp_insertion_multi_ts_field_merge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ts_field_merge: overwrites the timestamp field of a first beat by mode   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ts_field_merge
  import timestamp_insertion_multi_pkg::*;
#(
  parameter int TIMESTAMP_WIDTH      = 64,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int TS_TUSER_OFFSET      = 32,
  parameter int TS_TDATA_OFFSET      = 0
) (
  input  logic [1:0]                      mode,
  input  logic                            stamp_en,
  input  logic [TIMESTAMP_WIDTH-1:0]      timestamp,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0]  beat_tdata,
  input  logic [C_M_AXIS_TUSER_WIDTH-1:0] beat_tuser,
  input  logic [C_M_AXIS_DATA_WIDTH/8-1:0] beat_tstrb,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]  merged_tdata,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0] merged_tuser,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0] merged_tstrb
);

  localparam int c_STRB_W = C_M_AXIS_DATA_WIDTH / 8;

  logic [c_STRB_W-1:0] w_field_strb;

  // Byte lanes overlapped by the tdata timestamp field.
  for (genvar i = 0; i < c_STRB_W; i++) begin : g_field_strb
    localparam bit c_IN_FIELD = (i >= TS_TDATA_OFFSET / 8) &&
                                (i < (TS_TDATA_OFFSET + TIMESTAMP_WIDTH + 7) / 8);
    assign w_field_strb[i] = c_IN_FIELD;
  end

  always_comb begin
    merged_tdata = beat_tdata;
    merged_tuser = beat_tuser;
    merged_tstrb = beat_tstrb;
    if (stamp_en) begin
      case (mode)
        MODE_TUSER: merged_tuser[TS_TUSER_OFFSET +: TIMESTAMP_WIDTH] = timestamp;
        MODE_TDATA: begin
          merged_tdata[TS_TDATA_OFFSET +: TIMESTAMP_WIDTH] = timestamp;
          merged_tstrb = beat_tstrb | w_field_strb;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/timestamp_insertion_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | timestamp_insertion_multi: pairs pkt_start timestamps with AXIS packets  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module timestamp_insertion_multi
  import timestamp_insertion_multi_pkg::*;
#(
  parameter int TIMESTAMP_WIDTH      = 64,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int TS_TUSER_OFFSET      = 32,
  parameter int TS_TDATA_OFFSET      = 0,
  parameter int DATA_FIFO_DEPTH_BITS = 4,
  parameter int TS_FIFO_DEPTH_BITS   = 2,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [TIMESTAMP_WIDTH-1:0]        stamp_counter,
  input  logic                              pkt_start,
  input  logic [1:0]                        insert_mode,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_M_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [CNT_WIDTH-1:0]              ts_drop_count,
  output logic [CNT_WIDTH-1:0]              pkt_stamped_count
);

  localparam int c_STRB_W = C_M_AXIS_DATA_WIDTH / 8;
  localparam int c_BEAT_W = 1 + C_M_AXIS_TUSER_WIDTH + c_STRB_W + C_M_AXIS_DATA_WIDTH;

  if (TS_TUSER_OFFSET + TIMESTAMP_WIDTH > C_M_AXIS_TUSER_WIDTH) begin : g_chk_tuser
    $error("timestamp field exceeds tuser width");
  end
  if (TS_TDATA_OFFSET + TIMESTAMP_WIDTH > C_M_AXIS_DATA_WIDTH) begin : g_chk_tdata
    $error("timestamp field exceeds tdata width");
  end
  if (TS_TDATA_OFFSET % 8 != 0) begin : g_chk_align
    $error("TS_TDATA_OFFSET must be byte aligned");
  end

  state_t                            r_state;
  state_t                            w_state_next;
  logic [1:0]                        r_mode_q;
  logic [CNT_WIDTH-1:0]              r_drop_cnt;
  logic [CNT_WIDTH-1:0]              r_stamp_cnt;
  logic [c_BEAT_W-1:0]               w_data_dout;
  logic                              w_data_empty;
  logic                              w_data_nearly_full;
  logic                              w_unused_data_full;
  logic [TIMESTAMP_WIDTH-1:0]        w_ts_head;
  logic                              w_ts_empty;
  logic                              w_ts_full;
  logic                              w_unused_ts_nearly_full;
  logic                              w_head_last;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   w_head_user;
  logic [c_STRB_W-1:0]               w_head_strb;
  logic [C_M_AXIS_DATA_WIDTH-1:0]    w_head_data;
  logic                              w_hs;
  logic                              w_first_hs;
  logic                              w_stamp_mode;
  logic [1:0]                        w_merge_mode;

  assign s_axis_tready = !w_data_nearly_full;
  assign {w_head_last, w_head_user, w_head_strb, w_head_data} = w_data_dout;

  fallthrough_small_fifo #(
    .WIDTH          (c_BEAT_W),
    .MAX_DEPTH_BITS (DATA_FIFO_DEPTH_BITS)
  ) u_data_fifo (
    .clk         (clk),
    .reset       (reset),
    .din         ({s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata}),
    .wr_en       (s_axis_tvalid && s_axis_tready),
    .rd_en       (w_hs),
    .dout        (w_data_dout),
    .full        (w_unused_data_full),
    .nearly_full (w_data_nearly_full),
    .empty       (w_data_empty)
  );

  fallthrough_small_fifo #(
    .WIDTH          (TIMESTAMP_WIDTH),
    .MAX_DEPTH_BITS (TS_FIFO_DEPTH_BITS)
  ) u_ts_fifo (
    .clk         (clk),
    .reset       (reset),
    .din         (stamp_counter),
    .wr_en       (pkt_start && !w_ts_full),
    .rd_en       (w_first_hs),
    .dout        (w_ts_head),
    .full        (w_ts_full),
    .nearly_full (w_unused_ts_nearly_full),
    .empty       (w_ts_empty)
  );

  // First beats use the live mode; later beats carry the latched one but are never stamped.
  assign w_merge_mode = (r_state == IDLE) ? insert_mode : r_mode_q;

  ts_field_merge #(
    .TIMESTAMP_WIDTH      (TIMESTAMP_WIDTH),
    .C_M_AXIS_DATA_WIDTH  (C_M_AXIS_DATA_WIDTH),
    .C_M_AXIS_TUSER_WIDTH (C_M_AXIS_TUSER_WIDTH),
    .TS_TUSER_OFFSET      (TS_TUSER_OFFSET),
    .TS_TDATA_OFFSET      (TS_TDATA_OFFSET)
  ) u_merge (
    .mode         (w_merge_mode),
    .stamp_en     (r_state == IDLE),
    .timestamp    (w_ts_head),
    .beat_tdata   (w_head_data),
    .beat_tuser   (w_head_user),
    .beat_tstrb   (w_head_strb),
    .merged_tdata (m_axis_tdata),
    .merged_tuser (m_axis_tuser),
    .merged_tstrb (m_axis_tstrb)
  );

  assign m_axis_tlast      = w_head_last;
  assign ts_drop_count     = r_drop_cnt;
  assign pkt_stamped_count = r_stamp_cnt;
  assign w_hs              = m_axis_tvalid && m_axis_tready;
  assign w_first_hs        = w_hs && (r_state == IDLE);
  assign w_stamp_mode      = (insert_mode == MODE_TUSER) || (insert_mode == MODE_TDATA);

  always_comb begin
    w_state_next  = r_state;
    m_axis_tvalid = 1'b0;
    case (r_state)
      IDLE: begin
        m_axis_tvalid = !w_data_empty && !w_ts_empty;
        if (w_hs && !w_head_last) w_state_next = SEND;
      end
      SEND: begin
        m_axis_tvalid = !w_data_empty;
        if (w_hs && w_head_last) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mode_q    <= MODE_BYPASS;
      r_drop_cnt  <= '0;
      r_stamp_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_first_hs) r_mode_q <= insert_mode;
      // Full flag is the pre-pop value, so a strobe coinciding with a pop is still dropped.
      if (pkt_start && w_ts_full && (r_drop_cnt != '1))
        r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
      if (w_first_hs && w_stamp_mode && (r_stamp_cnt != '1))
        r_stamp_cnt <= r_stamp_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_timestamp_insertion_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_timestamp_insertion_multi: directed and random checks vs queue model  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_timestamp_insertion_multi;

  typedef struct packed {
    logic         last;
    logic [127:0] user;
    logic [31:0]  strb;
    logic [255:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  stamp_counter;
  logic         pkt_start;
  logic [1:0]   insert_mode;
  logic [255:0] s_axis_tdata;
  logic [127:0] s_axis_tuser;
  logic [31:0]  s_axis_tstrb;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic [255:0] m_axis_tdata;
  logic [127:0] m_axis_tuser;
  logic [31:0]  m_axis_tstrb;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready;
  logic [31:0]  ts_drop_count;
  logic [31:0]  pkt_stamped_count;

  always #5 clk = ~clk;

  timestamp_insertion_multi #(
    .TIMESTAMP_WIDTH      (64),
    .C_M_AXIS_DATA_WIDTH  (256),
    .C_M_AXIS_TUSER_WIDTH (128),
    .TS_TUSER_OFFSET      (32),
    .TS_TDATA_OFFSET      (0),
    .DATA_FIFO_DEPTH_BITS (4),
    .TS_FIFO_DEPTH_BITS   (2),
    .CNT_WIDTH            (32)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .stamp_counter     (stamp_counter),
    .pkt_start         (pkt_start),
    .insert_mode       (insert_mode),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tuser      (s_axis_tuser),
    .s_axis_tstrb      (s_axis_tstrb),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tready     (s_axis_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tuser      (m_axis_tuser),
    .m_axis_tstrb      (m_axis_tstrb),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tready     (m_axis_tready),
    .ts_drop_count     (ts_drop_count),
    .pkt_stamped_count (pkt_stamped_count)
  );

  // Reference model: queues of accepted beats and stored timestamps.
  beat_t        data_q[$];
  logic [63:0]  ts_q[$];
  bit           in_pkt;
  int unsigned  m_drop;
  int unsigned  m_stamped;
  beat_t        obs[$];

  int           n_checks = 0;
  int           n_err    = 0;

  bit           smp_reset, smp_in_hs, smp_out_hs, smp_pkt_start;
  logic [1:0]   smp_mode;
  logic [63:0]  smp_stamp;
  beat_t        smp_in_beat;
  bit           prev_stall;
  beat_t        prev_beat;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t stamp_beat(input beat_t b, input logic [1:0] m, input logic [63:0] ts);
    beat_t r;
    r = b;
    if (m == 2'd1) r.user[95:32] = ts;
    else if (m == 2'd2) begin
      r.data[63:0] = ts;
      r.strb[7:0]  = 8'hFF;
    end
    return r;
  endfunction

  function automatic beat_t rand_beat(input bit last);
    beat_t b;
    for (int i = 0; i < 8; i++) b.data[i*32 +: 32] = $urandom;
    for (int i = 0; i < 4; i++) b.user[i*32 +: 32] = $urandom;
    b.strb = $urandom;
    b.last = last;
    return b;
  endfunction

  task automatic check_outputs();
    bit    exp_tready, exp_valid;
    beat_t eb, db;
    exp_tready = data_q.size() < 15;
    exp_valid  = (data_q.size() > 0) && (in_pkt || ts_q.size() > 0);
    db = {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata};
    chk("s_tready", s_axis_tready, exp_tready);
    chk("m_tvalid", m_axis_tvalid, exp_valid);
    if (exp_valid) begin
      eb = in_pkt ? data_q[0] : stamp_beat(data_q[0], insert_mode, ts_q[0]);
      chk("m_beat", db, eb);
    end
    if (prev_stall) chk("stall_hold", db, prev_beat);
    chk("drop_count", ts_drop_count, m_drop);
    chk("stamped_count", pkt_stamped_count, m_stamped);
    if (m_axis_tvalid && m_axis_tready && !reset) obs.push_back(db);
    prev_stall    = exp_valid && !m_axis_tready && !reset;
    prev_beat     = db;
    smp_reset     = reset;
    smp_in_hs     = s_axis_tvalid && exp_tready;
    smp_out_hs    = exp_valid && m_axis_tready;
    smp_pkt_start = pkt_start;
    smp_mode      = insert_mode;
    smp_stamp     = stamp_counter;
    smp_in_beat   = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
  endtask

  task automatic model_update();
    bit ts_full_pre;
    if (smp_reset) begin
      data_q.delete();
      ts_q.delete();
      in_pkt     = 0;
      m_drop     = 0;
      m_stamped  = 0;
      prev_stall = 0;
      return;
    end
    ts_full_pre = (ts_q.size() == 4);
    if (smp_out_hs) begin
      beat_t h;
      h = data_q.pop_front();
      if (!in_pkt) begin
        void'(ts_q.pop_front());
        if (smp_mode == 2'd1 || smp_mode == 2'd2) m_stamped++;
      end
      in_pkt = !h.last;
    end
    if (smp_pkt_start) begin
      if (ts_full_pre) m_drop++;
      else ts_q.push_back(smp_stamp);
    end
    if (smp_in_hs) data_q.push_back(smp_in_beat);
  endtask

  // Called right after inputs are driven at a negative edge.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive_beat(input beat_t b, input bit valid);
    s_axis_tvalid = valid;
    s_axis_tdata  = b.data;
    s_axis_tuser  = b.user;
    s_axis_tstrb  = b.strb;
    s_axis_tlast  = b.last;
  endtask

  task automatic idle_ticks(input int n);
    s_axis_tvalid = 1'b0;
    pkt_start     = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic [63:0] ts);
    pkt_start     = 1'b1;
    stamp_counter = ts;
    tick();
    pkt_start     = 1'b0;
  endtask

  beat_t in_b[4];
  beat_t ob;

  initial begin
    reset = 1'b1; pkt_start = 1'b0; insert_mode = 2'd0; stamp_counter = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tuser = '0; s_axis_tstrb = '0;
    s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
    in_pkt = 0; m_drop = 0; m_stamped = 0; prev_stall = 0; prev_beat = '0;
    @(negedge clk);
    tick(); tick();
    reset = 1'b0;
    chk("reset_tvalid", m_axis_tvalid, 0);
    chk("reset_drop", ts_drop_count, 0);
    chk("reset_stamped", pkt_stamped_count, 0);
    chk("reset_tready", s_axis_tready, 1);

    // Mode 1, 3-beat packet
    insert_mode = 2'd1;
    strobe(64'h0000_0001_2345_6789);
    for (int b = 0; b < 3; b++) begin
      in_b[b] = rand_beat(b == 2);
      drive_beat(in_b[b], 1'b1);
      tick();
    end
    idle_ticks(4);
    chk("m1_beats", obs.size(), 3);
    ob = obs[0]; chk("m1_stamp", ob.user[95:32], 64'h0000_0001_2345_6789);
    chk("m1_lowuser", ob.user[31:0], in_b[0].user[31:0]);
    ob = obs[1]; chk("m1_beat1_user", ob.user, in_b[1].user);
    ob = obs[2]; chk("m1_beat2_user", ob.user, in_b[2].user);
    chk("m1_count", pkt_stamped_count, 1);
    obs.delete();

    // Mode 2, single beat with tstrb 0xF
    insert_mode = 2'd2;
    strobe(64'hA5A5_0000_1111_2222);
    in_b[0] = rand_beat(1'b1);
    in_b[0].strb = 32'h0000_000F;
    drive_beat(in_b[0], 1'b1);
    tick();
    idle_ticks(3);
    ob = obs[0];
    chk("m2_data", ob.data[63:0], 64'hA5A5_0000_1111_2222);
    chk("m2_upper", ob.data[255:64], in_b[0].data[255:64]);
    chk("m2_strb", ob.strb, 32'h0000_00FF);
    chk("m2_last", ob.last, 1);
    chk("m2_idle_tvalid", m_axis_tvalid, 0);
    obs.delete();

    // Data waits for a late timestamp
    insert_mode = 2'd1;
    in_b[0] = rand_beat(1'b1);
    drive_beat(in_b[0], 1'b1);
    tick();
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wait_ts_tvalid", m_axis_tvalid, 0);
    end
    strobe(64'h0BAD_CAFE_0000_0003);
    chk("ts_arrival_tvalid", m_axis_tvalid, 1);
    tick();
    ob = obs[0];
    chk("late_stamp", ob.user[95:32], 64'h0BAD_CAFE_0000_0003);
    obs.delete();

    // Timestamp FIFO overflow
    for (int i = 0; i < 6; i++) strobe(64'd100 + 64'(i));
    chk("overflow_drop", ts_drop_count, 2);
    for (int i = 0; i < 4; i++) begin
      drive_beat(rand_beat(1'b1), 1'b1);
      tick();
    end
    idle_ticks(4);
    chk("overflow_pkts", obs.size(), 4);
    for (int i = 0; i < 4; i++) begin
      ob = obs[i];
      chk("overflow_order", ob.user[95:32], 64'd100 + 64'(i));
    end
    chk("overflow_empty_tvalid", m_axis_tvalid, 0);
    obs.delete();

    // Backpressure 1-0-0-1 mid-packet
    m_axis_tready = 1'b0;
    strobe(64'h1234);
    for (int b = 0; b < 3; b++) begin
      in_b[b] = rand_beat(b == 2);
      drive_beat(in_b[b], 1'b1);
      tick();
    end
    s_axis_tvalid = 1'b0;
    foreach (in_b[k]) begin
      if (k < 3) begin
        m_axis_tready = (k == 0);
        tick();
      end
    end
    m_axis_tready = 1'b1;
    idle_ticks(3);
    chk("bp_beats", obs.size(), 3);
    for (int b = 1; b < 3; b++) begin
      ob = obs[b];
      chk("bp_data", ob.data, in_b[b].data);
    end
    obs.delete();

    // Mode switch during beat 2, then reset mid-packet
    insert_mode = 2'd1;
    strobe(64'h5555);
    for (int b = 0; b < 3; b++) begin
      in_b[b] = rand_beat(b == 2);
      if (b == 2) insert_mode = 2'd0;
      drive_beat(in_b[b], 1'b1);
      tick();
    end
    idle_ticks(3);
    ob = obs[0]; chk("switch_stamp", ob.user[95:32], 64'h5555);
    ob = obs[2]; chk("switch_tail", ob.user, in_b[2].user);
    chk("switch_count", pkt_stamped_count, 9);
    strobe(64'h6666);
    for (int b = 0; b < 2; b++) begin
      drive_beat(rand_beat(1'b0), 1'b1);
      tick();
    end
    s_axis_tvalid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_drop", ts_drop_count, 0);
    chk("rst_stamped", pkt_stamped_count, 0);
    idle_ticks(3);
    obs.delete();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive_beat(rand_beat(($urandom % 4) == 0), ($urandom % 4) != 0);
      pkt_start     = ($urandom % 4) == 0;
      stamp_counter = {$urandom, $urandom};
      m_axis_tready = ($urandom % 3) != 0;
      reset         = ($urandom % 500) == 0;
      if (!prev_stall) insert_mode = 2'($urandom);
      tick();
    end
    reset = 1'b0;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      s_axis_tvalid = 1'b0;
      pkt_start     = (c < 20);
      tick();
    end
    pkt_start = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
